// File: rtl/uart_7seg_multi_if.sv
// Bundle of the UART input and the display / receive-status outputs of
// uart_7seg_multi. The master side is the display block itself.
interface uart_7seg_multi_if #(
  parameter int DATA_BITS  = 8,
  parameter int NUM_DIGITS = 4
);
  logic                  uart_rx;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [DATA_BITS-1:0]  rx_data;
  logic                  byte_valid;
  logic                  frame_err;
  logic                  parity_err;

  modport master (
    input  uart_rx,
    output seg, digit_en, rx_data, byte_valid, frame_err, parity_err
  );

  modport slave (
    output uart_rx,
    input  seg, digit_en, rx_data, byte_valid, frame_err, parity_err
  );
endinterface

// File: rtl/uart_7seg_multi.sv
// UART receiver (configurable width / parity) feeding a shifting digit
// buffer that is shown on a time-multiplexed 7-segment display.
module uart_7seg_multi #(
  parameter int DELAY_FRAMES   = 234,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               reset,
  uart_7seg_multi_if.master bus
);

  localparam int CNT_W  = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic              INV       = (SEG_ACTIVE_LOW != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);
  localparam logic              PAR_EN    = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                  rx_meta_q, rx_q;
  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic [3:0]            digits_q [NUM_DIGITS];
  logic [3:0]            digits_d [NUM_DIGITS];
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [7:0]            byte_w;

  function automatic logic [6:0] seg_map(input logic [3:0] code);
    case (code)
      4'd0:    seg_map = 7'b0111111;
      4'd1:    seg_map = 7'b0001001;
      4'd2:    seg_map = 7'b1011110;
      4'd3:    seg_map = 7'b1011011;
      4'd4:    seg_map = 7'b1101001;
      4'd5:    seg_map = 7'b1110011;
      4'd6:    seg_map = 7'b1110111;
      4'd7:    seg_map = 7'b0011001;
      4'd8:    seg_map = 7'b1111111;
      4'd9:    seg_map = 7'b1111011;
      default: seg_map = 7'b0000000;
    endcase
  endfunction

  // Two-flop synchroniser on the asynchronous serial line, idling high.
  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= bus.uart_rx;
      rx_q      <= rx_meta_q;
    end
  end

  // Receive FSM next state: mid-bit sampling, parity check and end-of-frame flags.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rx_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rx_q) != PAR_ODD;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          frame_err_d  = !rx_q;
          parity_err_d = par_bad_q;
          if (rx_q && !par_bad_q) begin
            rx_data_d    = shift_q;
            byte_valid_d = 1'b1;
          end
          state_d = rx_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign byte_w = 8'(shift_q);

  // Decode an accepted byte into a digit push or a clear of the buffer.
  always_comb begin
    digits_d = digits_q;
    if (byte_valid_d) begin
      if (byte_w <= 8'h09 || (byte_w >= 8'h30 && byte_w <= 8'h39)) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
        digits_d[0] = byte_w[3:0];
      end else if (byte_w == 8'h43 || byte_w == 8'h63) begin
        for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = 4'hF;
      end
    end
  end

  // Digit buffer, blanked by reset.
  // NOTE: this small register array is reset explicitly; it is flops, not a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'hF;
    end else begin
      digits_q <= digits_d;
    end
  end

  // Free-running scan divider and registered segment / enable drive.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    seg_d = seg_map(digits_q[idx_q]) ^ {7{INV}};
    en_d  = (NUM_DIGITS'(1) << idx_q) ^ {NUM_DIGITS{INV}};
  end

  // Scan registers; outputs reset to their inactive level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= {7{INV}};
      en_q       <= {NUM_DIGITS{INV}};
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      en_q       <= en_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.digit_en   = en_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;

endmodule
